controller_sseg_mux: RTL and testbench

Multiplexed N-digit seven-segment display controller with an Avalon-MM slave register port. It is the multi-digit successor to the single-value seven-segment output port. Software writes per-digit raw segment patterns or hex nibbles, and the block scans them onto shared segment lines with one-hot digit enables. Per-digit values are double-buffered so a display frame never tears, and the block adds brightness PWM and per-digit blink. It sits between the Nios II/Avalon interconnect and the board display pins.

---
 rtl/controller_sseg_mux.sv | 208 ++++++++++++++++++++
 tb/tb_controller_sseg_mux.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/controller_sseg_mux.sv
// Multiplexed seven-segment display controller with an Avalon-MM register port.
// Software writes raw segment patterns or hex nibbles per digit; the block scans them
// onto shared segment lines with one-hot digit enables, brightness PWM and per-digit blink.
// Digit values are double-buffered so a frame never tears.
module controller_sseg_mux #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_sync
);

  localparam int unsigned PW       = $clog2(SCAN_DIV);
  localparam int unsigned FW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned SlotUnit = SCAN_DIV / 16;

  localparam logic [PW-1:0]         LastPresc = PW'(SCAN_DIV - 1);
  localparam logic [2:0]            LastIdx   = 3'(NUM_DIGITS - 1);
  localparam logic [FW-1:0]         LastFrame = FW'(BLINK_FRAMES - 1);
  localparam logic [6:0]            SegOff    = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DigOff    = {NUM_DIGITS{ACTIVE_LOW}};

  localparam logic [3:0] AddrStatus = 4'd14;
  localparam logic [3:0] AddrCtrl   = 4'd15;

  // Register file
  logic [6:0]            staging_q [NUM_DIGITS];
  logic [6:0]            staging_d [NUM_DIGITS];
  logic [6:0]            display_q [NUM_DIGITS];
  logic [6:0]            display_d [NUM_DIGITS];
  logic                  enable_q, enable_d;
  logic                  hex_mode_q, hex_mode_d;
  logic [3:0]            bright_q, bright_d;
  logic [NUM_DIGITS-1:0] blink_mask_q, blink_mask_d;

  // Scan state
  logic [PW-1:0]         presc_q, presc_d;
  logic [2:0]            idx_q, idx_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  frame_sync_q, frame_sync_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  logic wr, ctrl_wr, run, presc_last, idx_last, wrap;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  // Register writes, scan counters, shadow copy and blink bookkeeping
  always_comb begin
    wr      = chipselect & ~write_n;
    ctrl_wr = wr && (address == AddrCtrl);

    enable_d     = ctrl_wr ? writedata[0] : enable_q;
    hex_mode_d   = ctrl_wr ? writedata[1] : hex_mode_q;
    bright_d     = ctrl_wr ? writedata[7:4] : bright_q;
    blink_mask_d = ctrl_wr ? writedata[8 +: NUM_DIGITS] : blink_mask_q;

    // Counters only run while enable is set both now and next cycle, so a re-enable
    // starts digit 0 at full length and a disable parks them at 0 immediately.
    run        = enable_q & enable_d;
    presc_last = (presc_q == LastPresc);
    idx_last   = (idx_q == LastIdx);
    wrap       = run & presc_last & idx_last;

    presc_d = '0;
    idx_d   = '0;
    if (run) begin
      presc_d = presc_last ? '0 : presc_q + 1'b1;
      idx_d   = idx_q;
      if (presc_last) idx_d = idx_last ? 3'd0 : idx_q + 3'd1;
    end

    frame_sync_d  = wrap;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wrap) begin
      if (frame_cnt_q == LastFrame) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    // Shadow copy uses the pre-write staging value
    for (int i = 0; i < NUM_DIGITS; i++) begin
      staging_d[i] = staging_q[i];
      display_d[i] = display_q[i];
      if (wr && (address == 4'(i))) staging_d[i] = writedata[6:0];
      if (!enable_q || wrap) display_d[i] = staging_q[i];
    end
  end

  // Pattern and visibility for the slot currently addressed by prescaler/index
  always_comb begin
    logic [6:0]            raw;
    logic [6:0]            pattern;
    logic                  mask_bit;
    logic [NUM_DIGITS-1:0] onehot;
    logic [31:0]           lit_limit;
    logic                  visible;

    raw      = '0;
    mask_bit = 1'b0;
    onehot   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        raw       = display_q[i];
        mask_bit  = blink_mask_q[i];
        onehot[i] = 1'b1;
      end
    end
    pattern   = hex_mode_q ? hex_seg(raw[3:0]) : raw;
    lit_limit = (32'(bright_q) + 32'd1) * SlotUnit;
    visible   = enable_q && (32'(presc_q) < lit_limit) && !(mask_bit && blink_phase_q);

    seg_d = visible ? (pattern ^ SegOff) : SegOff;
    dig_d = visible ? (onehot ^ DigOff) : DigOff;
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (address == 4'(i)) readdata = {25'b0, staging_q[i]};
    end
    if (address == AddrCtrl) begin
      readdata = {16'b0, 8'(blink_mask_q), bright_q, 2'b0, hex_mode_q, enable_q};
    end
    if (address == AddrStatus) begin
      readdata = {23'b0, blink_phase_q, 5'b0, idx_q};
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        staging_q[i] <= '0;
        display_q[i] <= '0;
      end
      enable_q      <= 1'b0;
      hex_mode_q    <= 1'b0;
      bright_q      <= '0;
      blink_mask_q  <= '0;
      presc_q       <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      frame_sync_q  <= 1'b0;
      seg_q         <= SegOff;
      dig_q         <= DigOff;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        staging_q[i] <= staging_d[i];
        display_q[i] <= display_d[i];
      end
      enable_q      <= enable_d;
      hex_mode_q    <= hex_mode_d;
      bright_q      <= bright_d;
      blink_mask_q  <= blink_mask_d;
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_sync_q  <= frame_sync_d;
      seg_q         <= seg_d;
      dig_q         <= dig_d;
    end
  end

  assign seg_out    = seg_q;
  assign dig_en     = dig_q;
  assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_controller_sseg_mux.sv
// Bench for controller_sseg_mux: directed scenarios followed by random register traffic,
// every cycle compared against a model driven by a single elapsed-cycle count.
module tb_controller_sseg_mux;

  localparam int ND = 4;
  localparam int SD = 32;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [6:0]  seg_out;
  logic [3:0]  dig_en;
  logic        frame_sync;

  int checks = 0;
  int errors = 0;

  // Reference model: n = cycles elapsed since the scan was last (re)started
  logic [6:0] m_stage [ND];
  logic [6:0] m_disp [ND];
  logic       m_en, m_hex;
  logic [3:0] m_br, m_mask;
  int         n, frames;
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  controller_sseg_mux #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLINK_FRAMES(BF),
    .ACTIVE_LOW  (1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .seg_out   (seg_out),
    .dig_en    (dig_en),
    .frame_sync(frame_sync)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_stage[i] = '0;
      m_disp[i]  = '0;
    end
    m_en = 1'b0; m_hex = 1'b0; m_br = '0; m_mask = '0;
    n = 0; frames = 0;
  endtask

  function automatic bit cur_phase();
    return ((frames / BF) % 2) != 0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (a < 4'(ND)) return {25'b0, m_stage[a[1:0]]};
    if (a == 4'd15) return {16'b0, 4'b0, m_mask, m_br, 2'b0, m_hex, m_en};
    if (a == 4'd14) return {23'b0, cur_phase(), 5'b0, 3'((n / SD) % ND)};
    return 32'h0;
  endfunction

  // One clock: drive a bus cycle, predict the pins, advance the model, compare
  task automatic step(input bit wr, input logic [3:0] a, input logic [31:0] wd);
    logic [6:0] e_seg;
    logic [3:0] e_dig;
    logic [1:0] d;
    bit         e_fs, new_en, old_en;
    int         p;
    e_seg = '0;
    e_dig = '0;
    if (m_en) begin
      p = n % SD;
      d = 2'((n / SD) % ND);
      if (p < (int'(m_br) + 1) * (SD / 16) && !(m_mask[d] && cur_phase())) begin
        e_seg = m_hex ? hex_tab[m_disp[d][3:0]] : m_disp[d];
        e_dig = 4'b0001 << d;
      end
    end
    old_en = m_en;
    new_en = (wr && a == 4'd15) ? wd[0] : m_en;
    e_fs   = old_en && new_en && (((n + 1) % (SD * ND)) == 0);

    address = a; chipselect = wr; write_n = !wr; writedata = wd;
    @(posedge clk);
    if (!old_en || e_fs) begin
      for (int i = 0; i < ND; i++) m_disp[i] = m_stage[i];
    end
    if (wr) begin
      if (a < 4'(ND)) m_stage[a[1:0]] = wd[6:0];
      else if (a == 4'd15) begin
        m_en = wd[0]; m_hex = wd[1]; m_br = wd[7:4]; m_mask = wd[11:8];
      end
    end
    if (e_fs) frames++;
    n = (old_en && new_en) ? n + 1 : 0;
    #1;
    chipselect = 1'b0; write_n = 1'b1;
    check("seg_out", 32'(seg_out), 32'(e_seg));
    check("dig_en", 32'(dig_en), 32'(e_dig));
    check("frame_sync", 32'(frame_sync), 32'(e_fs));
    check("readdata", readdata, exp_rd(a));
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b0, 4'($urandom_range(15)), 32'h0);
  endtask

  initial begin
    int         k;
    logic [3:0] ra;
    logic [31:0] rw;
    model_reset();
    #20;
    check("reset_seg", 32'(seg_out), 32'h0);
    check("reset_dig", 32'(dig_en), 32'h0);
    check("reset_fs", 32'(frame_sync), 32'h0);
    #3;
    reset = 1'b0;

    // Raw scan
    step(1'b1, 4'd0, 32'h3F);
    step(1'b1, 4'd1, 32'h06);
    step(1'b1, 4'd15, 32'hF1);
    idle(260);

    // Hex mode
    step(1'b1, 4'd2, 32'h0A);
    step(1'b1, 4'd15, 32'hF3);
    idle(260);

    // Brightness
    step(1'b1, 4'd15, 32'h31);
    idle(160);

    // Shadow: mid-frame write, then a write in the frame_sync cycle
    step(1'b1, 4'd15, 32'hF1);
    idle(40);
    step(1'b1, 4'd0, 32'h5B);
    idle(200);
    k = 0;
    while (frame_sync !== 1'b1 && k < 200) begin
      idle(1);
      k++;
    end
    check("fs_seen", 32'(frame_sync), 32'h1);
    step(1'b1, 4'd0, 32'h4F);
    idle(300);

    // Blink on digit 2, then freeze with enable=0, then resume
    step(1'b1, 4'd15, 32'h4F1);
    idle(640);
    step(1'b1, 4'd15, 32'h4F0);
    idle(60);
    step(1'b1, 4'd15, 32'h4F1);
    idle(300);

    // Asynchronous reset mid-scan
    #2;
    reset = 1'b1;
    #1;
    check("rst_seg", 32'(seg_out), 32'h0);
    check("rst_dig", 32'(dig_en), 32'h0);
    check("rst_fs", 32'(frame_sync), 32'h0);
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      check("rst_rd", readdata, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Random register traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(15) == 0) begin
        ra = ($urandom_range(3) == 0) ? 4'd15 : 4'($urandom_range(15));
        rw = $urandom;
        if (ra == 4'd15) rw[0] = ($urandom_range(7) != 0);
        step(1'b1, ra, rw);
      end else begin
        idle(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
